// File: rtl/cpu_pio_pkg.sv
// Shared constants for the memory-mapped input PIO family.
// Register offsets and the encodings of the capture and interrupt modes.
package cpu_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;
    localparam int EDGE_ANY  = 3;

    localparam int IRQ_NONE  = 0;
    localparam int IRQ_LEVEL = 1;
    localparam int IRQ_EDGE  = 2;

endpackage

// File: rtl/cpu_pio_sync.sv
// Multi-flop synchroniser for a bus of asynchronous inputs.
// Every stage resets to 0, so nothing looks like an edge right after reset.
module cpu_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stages [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stages[i] <= '0;
            end
        end else begin
            r_stages[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_input_pio_irq.sv
// Avalon-MM slave input port with synchronisation, per-bit edge capture
// and a maskable interrupt for the Nios II interrupt controller.
module cpu_input_pio_irq
    import cpu_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1,
    parameter int IRQ_TYPE    = 2,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_dataIn;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clearMask;
    logic [WIDTH-1:0] w_edgeNext;
    logic [WIDTH-1:0] w_readMux;
    logic             w_write;
    logic             w_irqNext;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCap;
    logic [WIDTH-1:0] r_readData;
    logic             r_irq;

    cpu_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_dataIn)
    );

    assign w_write = chipselect && !write_n;

    always_comb begin
        w_event = '0;
        case (EDGE_TYPE)
            EDGE_RISE: w_event = w_dataIn & ~r_prev;
            EDGE_FALL: w_event = ~w_dataIn & r_prev;
            EDGE_ANY:  w_event = w_dataIn ^ r_prev;
            default:   w_event = '0;
        endcase
    end

    // Clearing is applied before the new events are OR-ed in, so a set in the
    // same cycle as a clear leaves the bit at 1.
    always_comb begin
        w_clearMask = '0;
        if (w_write && address == PIO_ADDR_EDGE) begin
            w_clearMask = (BIT_CLEAR != 0) ? writedata : '1;
        end
        if (EDGE_TYPE == EDGE_NONE) begin
            w_edgeNext = '0;
        end else begin
            w_edgeNext = (r_edgeCap & ~w_clearMask) | w_event;
        end
    end

    always_comb begin
        w_readMux = '0;
        case (address)
            PIO_ADDR_DATA:    w_readMux = w_dataIn;
            PIO_ADDR_IRQMASK: w_readMux = r_irqMask;
            PIO_ADDR_EDGE:    w_readMux = r_edgeCap;
            default:          w_readMux = '0;
        endcase
    end

    always_comb begin
        w_irqNext = 1'b0;
        case (IRQ_TYPE)
            IRQ_LEVEL: w_irqNext = |(w_dataIn & r_irqMask);
            IRQ_EDGE:  w_irqNext = |(r_edgeCap & r_irqMask);
            default:   w_irqNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_irqMask  <= '0;
            r_edgeCap  <= '0;
            r_readData <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_dataIn;
            r_edgeCap  <= w_edgeNext;
            r_readData <= w_readMux;
            r_irq      <= w_irqNext;
            if (w_write && address == PIO_ADDR_IRQMASK) begin
                r_irqMask <= writedata;
            end
        end
    end

    assign readdata = r_readData;
    assign irq      = r_irq;

endmodule

// File: tb/tb_cpu_input_pio_irq.sv
// Bench for the input PIO: a default 32-bit instance plus an 8-bit
// any-edge, level-interrupt, clear-all instance sharing clock and reset.
module tb_cpu_input_pio_irq;

    typedef struct {
        logic        dut;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } stimVec_t;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [1:0]  aAddr;
    logic        aCs;
    logic        aWn;
    logic [31:0] aWdata;
    logic [31:0] aIn;
    logic [31:0] aRd;
    logic        aIrq;

    logic [1:0]  bAddr;
    logic        bCs;
    logic        bWn;
    logic [7:0]  bWdata;
    logic [7:0]  bIn;
    logic [7:0]  bRd;
    logic        bIrq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ [$];
    string       nameQ [$];
    stimVec_t    vecs [10];

    always #5 clk = ~clk;

    cpu_input_pio_irq dutA (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (aAddr),
        .chipselect (aCs),
        .write_n    (aWn),
        .writedata  (aWdata),
        .in_port    (aIn),
        .readdata   (aRd),
        .irq        (aIrq)
    );

    cpu_input_pio_irq #(
        .WIDTH       (8),
        .SYNC_STAGES (3),
        .EDGE_TYPE   (3),
        .IRQ_TYPE    (1),
        .BIT_CLEAR   (0)
    ) dutB (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (bAddr),
        .chipselect (bCs),
        .write_n    (bWn),
        .writedata  (bWdata),
        .in_port    (bIn),
        .readdata   (bRd),
        .irq        (bIrq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; a read expectation is queued when the access is driven
    // and retired against readdata one clock later.
    task automatic applyStimulus(input logic dut, input logic wr, input logic [1:0] addr,
                                 input logic [31:0] data, input logic chk,
                                 input logic [31:0] exp, input string name);
        logic [31:0] e;
        string       n;
        if (dut == 1'b0) begin
            aCs = 1'b1; aWn = !wr; aAddr = addr; aWdata = data;
        end else begin
            bCs = 1'b1; bWn = !wr; bAddr = addr; bWdata = data[7:0];
        end
        if (chk) begin
            expQ.push_back(exp);
            nameQ.push_back(name);
        end
        tick();
        aCs = 1'b0; aWn = 1'b1; bCs = 1'b0; bWn = 1'b1;
        if (chk) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, (dut == 1'b0) ? aRd : {24'h0, bRd}, e);
        end
    endtask

    task automatic pulseA(input logic [31:0] mask);
        aIn = mask;
        repeat (4) tick();
        aIn = '0;
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        aAddr = 2'd0; aCs = 1'b0; aWn = 1'b1; aWdata = '0; aIn = 32'hFFFF_FFFF;
        bAddr = 2'd0; bCs = 1'b0; bWn = 1'b1; bWdata = '0; bIn = 8'hFF;

        repeat (3) tick();
        checkOutput("aResetRead", aRd, 32'h0);
        checkOutput("aResetIrq", {31'h0, aIrq}, 32'h0);
        checkOutput("bResetRead", {24'h0, bRd}, 32'h0);
        checkOutput("bResetIrq", {31'h0, bIrq}, 32'h0);

        reset_n = 1'b1;
        tick();
        tick();
        applyStimulus(0, 0, 2'd0, 0, 1, 32'hFFFF_FFFF, "dataAfterReset");
        applyStimulus(0, 0, 2'd3, 0, 1, 32'hFFFF_FFFF, "edgeAfterReset");
        applyStimulus(0, 1, 2'd3, 32'hFFFF_FFFF, 0, 0, "");
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h0, "edgeClearedAll");
        aIn = '0;
        repeat (4) tick();
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h0, "noFallCapture");

        pulseA(32'h20);
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h20, "riseCapture");
        applyStimulus(0, 1, 2'd3, 32'h20, 0, 0, "");
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h0, "w1cClear");
        pulseA(32'h20);
        applyStimulus(0, 1, 2'd3, 32'h01, 0, 0, "");
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h20, "keepOnOtherClear");

        applyStimulus(0, 1, 2'd3, 32'h20, 0, 0, "");
        applyStimulus(0, 1, 2'd2, 32'h20, 0, 0, "");
        applyStimulus(0, 0, 2'd2, 0, 1, 32'h20, "maskReadback");
        checkOutput("irqIdle", {31'h0, aIrq}, 32'h0);
        aIn = 32'h20;
        repeat (3) tick();
        checkOutput("irqSameEdgeAsCapture", {31'h0, aIrq}, 32'h0);
        tick();
        checkOutput("irqAfterCapture", {31'h0, aIrq}, 32'h1);
        aIn = '0;
        applyStimulus(0, 1, 2'd2, 32'h0, 0, 0, "");
        tick();
        checkOutput("irqMasked", {31'h0, aIrq}, 32'h0);
        applyStimulus(0, 1, 2'd2, 32'h20, 0, 0, "");
        tick();
        checkOutput("irqUnmasked", {31'h0, aIrq}, 32'h1);
        applyStimulus(0, 1, 2'd3, 32'h20, 0, 0, "");
        tick();
        checkOutput("irqCleared", {31'h0, aIrq}, 32'h0);

        aIn = 32'h08;
        tick();
        tick();
        applyStimulus(0, 1, 2'd3, 32'h08, 1, 32'h0, "preUpdateRead");
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h08, "setWinsClear");

        vecs[0] = '{1'b0, 1'b1, 2'd0, 32'h1234_5678, 1'b0, 32'h0, "wrData"};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, "wrAddr1"};
        vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0, "addr1ReadsZero"};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h08, "dataUnchanged"};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h0, 1'b1, 32'h20, "maskUnchanged"};
        vecs[5] = '{1'b0, 1'b0, 2'd3, 32'h0, 1'b1, 32'h08, "edgeUnchanged"};
        vecs[6] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_0000, 1'b0, 32'h0, "wrMaskHigh"};
        vecs[7] = '{1'b0, 1'b0, 2'd2, 32'h0, 1'b1, 32'hFFFF_0000, "maskHigh"};
        vecs[8] = '{1'b0, 1'b1, 2'd2, 32'h0000_000F, 1'b0, 32'h0, "wrMaskLow"};
        vecs[9] = '{1'b0, 1'b0, 2'd2, 32'h0, 1'b1, 32'h0000_000F, "maskLow"};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].data,
                          vecs[i].chk, vecs[i].exp, vecs[i].name);
        end

        bIn = 8'h00;
        repeat (6) tick();
        applyStimulus(1, 1, 2'd3, 32'h0, 0, 0, "");
        applyStimulus(1, 0, 2'd3, 0, 1, 32'h0, "bCleared");
        bIn = 8'h81;
        repeat (6) tick();
        bIn = 8'h00;
        repeat (6) tick();
        applyStimulus(1, 0, 2'd3, 0, 1, 32'h81, "bAnyEdge");
        applyStimulus(1, 1, 2'd3, 32'h0, 0, 0, "");
        applyStimulus(1, 0, 2'd3, 0, 1, 32'h0, "bAnyWriteClears");
        applyStimulus(1, 1, 2'd2, 32'h80, 0, 0, "");
        bIn = 8'h80;
        repeat (3) tick();
        checkOutput("bIrqBeforeSync", {31'h0, bIrq}, 32'h0);
        tick();
        checkOutput("bIrqLevelHigh", {31'h0, bIrq}, 32'h1);
        bIn = 8'h01;
        repeat (4) tick();
        checkOutput("bIrqFollowsBit7", {31'h0, bIrq}, 32'h0);

        checkOutput("aIrqBeforeReset", {31'h0, aIrq}, 32'h1);
        aIn = '0;
        bIn = '0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("aMidResetRead", aRd, 32'h0);
        checkOutput("aMidResetIrq", {31'h0, aIrq}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        applyStimulus(0, 0, 2'd3, 0, 1, 32'h0, "edgeAfterMidReset");
        applyStimulus(0, 0, 2'd2, 0, 1, 32'h0, "maskAfterMidReset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_input_pio_irq.md
Name: cpu_input_pio_irq

Overview:
- Parametrised Avalon-MM slave input PIO that generalises the team's fixed 32-bit read-only input ports.
- Adds configurable width, input synchronisation, per-bit edge capture and a maskable interrupt.
- Sits between asynchronous fabric signals (classifier status, distance results, buttons) and the Nios II data master, with irq routed to the CPU interrupt controller.

Parameters:
- WIDTH, 32: port and data-bus width, 1..32.
- SYNC_STAGES, 2: synchroniser flops on in_port, 2..4.
- EDGE_TYPE, 1: capture mode. 0 = none, 1 = rising, 2 = falling, 3 = any.
- IRQ_TYPE, 2: interrupt mode. 0 = none, 1 = level, 2 = edge.
- BIT_CLEAR, 1: edgecapture clear mode. 1 = write-1-to-clear per bit; 0 = any write clears all bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- in_port  in  WIDTH  external inputs, asynchronous to clk.
- readdata  out  WIDTH  registered read data.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; all flops are clocked on the rising edge of clk.
- Reset values: readdata 0, irq 0, synchroniser chain 0, previous-sample register 0, irqmask 0, edgecapture 0.
- Synchroniser: in_port passes through SYNC_STAGES flops to produce data_in. An in_port change reaches data_in after SYNC_STAGES clocks.
- Edge detect: prev <= data_in every clock. Per-bit event:
  - rising: data_in & ~prev
  - falling: ~data_in & prev
  - any: data_in ^ prev
- Register map:
  - 0 DATA: reads data_in. Writes are ignored.
  - 1: reads 0. Writes are ignored.
  - 2 IRQMASK: read/write, WIDTH bits.
  - 3 EDGECAPTURE:
    - Reads the captured bits.
    - A write with BIT_CLEAR=1 clears the bits set in writedata.
    - A write with BIT_CLEAR=0 clears all bits.
- A write occurs when chipselect=1 and write_n=0, and takes effect at the next clock edge.
- edgecapture set/clear: each bit sets on its event. If an event and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- EDGE_TYPE=0: edgecapture is held at 0 and writes to address 3 are ignored.
- Read timing:
  - readdata <= mux(address) every clock, independent of chipselect. Fixed read latency is 1.
  - A read of EDGECAPTURE in the same cycle as a new event returns the pre-update value.
- irq, registered (1 clock after the source register updates):
  - IRQ_TYPE=1: irq <= |(data_in & irqmask).
  - IRQ_TYPE=2: irq <= |(edgecapture & irqmask).
  - IRQ_TYPE=0: irq held at 0.
- irq stays asserted until the source is cleared or masked.
- Reset mid-operation: all state returns to reset values immediately.
- After reset release, the first SYNC_STAGES+1 clocks produce no spurious edges, because the chain and prev both reset to 0. Inputs already high at reset release do register as a rising edge once synchronised.
- Bits above WIDTH: none exist. Address decoding uses all 2 bits; there is no aliasing.

Decomposition:
- Package cpu_pio_pkg holds:
  - address constants: PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGE=3
  - EDGE_* encodings: NONE/RISE/FALL/ANY = 0..3
  - IRQ_* encodings: NONE/LEVEL/EDGE = 0..2
- Sub-module cpu_pio_sync (WIDTH, SYNC_STAGES): a reset-to-0 multi-flop synchroniser, reused by future input PIOs.

Test Plan:
- Reset: hold reset_n=0 with in_port=32'hFFFF_FFFF -> readdata=0 and irq=0. Release reset, read address 0 -> 32'hFFFF_FFFF returned 1 clock after the request, once in_port has passed through SYNC_STAGES.
- Rising capture (EDGE_TYPE=1): in_port bit 5 goes 0->1->0 -> EDGECAPTURE reads 32'h20. Write 32'h20 to address 3 -> next read returns 0. Write 32'h01 instead -> 32'h20 is retained.
- Interrupt (IRQ_TYPE=2):
  - IRQMASK=32'h20 and a bit-5 edge -> irq=1 one clock after edgecapture sets.
  - IRQMASK=0 -> irq=0 next clock.
  - Clearing edgecapture -> irq=0.
- Simultaneous set and clear: bit-3 rising event in the same cycle as a write of 32'h08 to address 3 -> bit 3 stays 1.
- Configuration sweep:
  - WIDTH=8, EDGE_TYPE=3, BIT_CLEAR=0: toggles on bits 0 and 7 -> EDGECAPTURE=8'h81. Any write to address 3 -> 8'h00.
  - IRQ_TYPE=1 with IRQMASK=8'h80 -> irq follows bit 7 of data_in.
- Ignored accesses: writes to addresses 0 and 1 -> no state change; address 1 reads 0. Assert reset mid-capture -> edgecapture and irqmask return to 0.
